// File: rtl/alu_dispatch.sv
// ALU dispatch: registered one-hot unit enables with per-unit occupancy tracking.
// Multi-cycle units hold off new requests until their occupancy counter drains.

module alu_occ_ctr #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic load,
  output logic busy
);
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (flush)        cnt <= '0;
    else if (load)         cnt <= 8'(CYCLES);
    else if (cnt != 8'd0)  cnt <= cnt - 8'd1;
  end

  assign busy = (cnt != 8'd0);
endmodule

module alu_dispatch #(
  parameter  int FUN_WIDTH = 2,
  localparam int NUM_UNITS = 2**FUN_WIDTH,
  parameter  logic [NUM_UNITS-1:0] MULTI_MASK = '0,
  parameter  int MULTI_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [FUN_WIDTH-1:0] alu_fun,
  input  logic                 flush,
  output logic                 in_ready,
  output logic [NUM_UNITS-1:0] unit_en,
  output logic [NUM_UNITS-1:0] unit_busy,
  output logic [FUN_WIDTH-1:0] fun_q
);
  logic                 accept;
  logic [NUM_UNITS-1:0] en_d;

  // flush and reset both gate ready, so accept is already suppressed under either
  assign in_ready = ~unit_busy[alu_fun] & ~flush & rst;
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
    assign en_d[k] = accept && (alu_fun == FUN_WIDTH'(k));
    if (MULTI_MASK[k]) begin : g_multi
      alu_occ_ctr #(.CYCLES(MULTI_CYCLES)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (en_d[k]),
        .busy  (unit_busy[k])
      );
    end else begin : g_single
      assign unit_busy[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_en <= '0;
      fun_q   <= '0;
    end else begin
      unit_en <= en_d;
      if (accept) fun_q <= alu_fun;
    end
  end
endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL provide parameter FUN_WIDTH, default 2, width of the function-select code.
REQ-002 SHALL derive NUM_UNITS = 2**FUN_WIDTH, one enable bit per functional unit; not overridable.
REQ-003 SHALL provide parameter MULTI_MASK, default all zeros (NUM_UNITS bits), where bit k set marks unit k as multi-cycle.
REQ-004 SHALL provide parameter MULTI_CYCLES, default 4, range 1..255, the number of cycles a multi-cycle unit stays occupied per operation.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  an operation request is present.
REQ-008 SHALL have port alu_fun  input  FUN_WIDTH  unit select of the presented request.
REQ-009 SHALL have port flush  input  1  synchronous abort of all in-flight occupancy.
REQ-010 SHALL have port in_ready  output  1  the request on alu_fun can be accepted this cycle.
REQ-011 SHALL have port unit_en  output  NUM_UNITS  registered one-hot enable; bit k = unit k starts an operation.
REQ-012 SHALL have port unit_busy  output  NUM_UNITS  bit k = multi-cycle unit k occupied.
REQ-013 SHALL have port fun_q  output  FUN_WIDTH  registered copy of the last accepted alu_fun.

Function
REQ-014 SHALL define accept = in_valid AND in_ready, sampled at a rising clk edge.
REQ-015 SHALL drive in_ready combinationally = NOT unit_busy[alu_fun] AND NOT flush AND rst.
REQ-016 SHALL, on accept at edge T, drive unit_en one-hot with bit alu_fun set for exactly the cycle following T (1-cycle latency), and fun_q = alu_fun from T onward.
REQ-017 SHALL drive unit_en = 0 in every cycle not following an accept; unit_en never has more than one bit set.
REQ-018 SHALL hold fun_q unchanged when no accept occurs.
REQ-019 SHALL keep one 8-bit occupancy counter per unit with MULTI_MASK bit set; unit_busy[k] = (counter k != 0); unit_busy[k] tied 0 for single-cycle units.
REQ-020 SHALL load counter k with MULTI_CYCLES on accept to unit k, else decrement it when nonzero, else hold 0.
REQ-021 SHALL therefore assert unit_busy[k] for MULTI_CYCLES cycles starting the cycle after accept; next accept to unit k earliest at edge T+MULTI_CYCLES+1.
REQ-022 SHALL accept single-cycle units on every consecutive cycle (full throughput).
REQ-023 SHALL allow accepts to any non-busy unit while other units are busy; counters are independent.
REQ-024 SHALL, when in_valid is high and in_ready low, neither update unit_en, fun_q, nor any counter (request stalls; source holds it).
REQ-025 SHALL, on flush high at an edge, clear all counters and unit_en to 0 at that edge, accept nothing that cycle, and leave fun_q unchanged; flush has priority over accept.
REQ-026 SHALL treat alu_fun as don't-care when in_valid is low.

Reset
REQ-027 SHALL, while rst is low, asynchronously force unit_en = 0, unit_busy = 0, fun_q = 0, all counters = 0, in_ready = 0.
REQ-028 SHALL, on rst assertion mid-operation, abort all occupancy immediately; no enable is issued from a request pending at reset.
REQ-029 SHALL accept a request at the first rising edge after rst deasserts, with no additional idle cycles.

Verification (FUN_WIDTH=2, MULTI_MASK=4'b0100, MULTI_CYCLES=3)
REQ-030 SHALL cover: after reset, in_valid=1, alu_fun=0,1,3 on three consecutive edges -> unit_en = 0001, 0010, 1000 on the three following cycles, in_ready stays 1, fun_q = 3 at the end.
REQ-031 SHALL cover: accept alu_fun=2 at edge T, hold in_valid=1, alu_fun=2 -> unit_en=0100 for one cycle, unit_busy[2]=1 cycles T+1..T+3, in_ready=0 until after edge T+3, second unit_en=0100 in the cycle after edge T+4.
REQ-032 SHALL cover: unit 2 busy, present alu_fun=0 -> in_ready=1, accepted, unit_en=0001 next cycle, unit_busy[2] continues counting down.
REQ-033 SHALL cover: accept alu_fun=2, flush=1 one cycle later with in_valid=1, alu_fun=1 -> unit_busy=0 and unit_en=0 after the flush edge, no accept at that edge, alu_fun=1 accepted at the next edge.
REQ-034 SHALL cover: rst driven low asynchronously (between edges) while unit_busy[2]=1 -> unit_en, unit_busy, fun_q = 0 immediately, in_ready=0; after release, alu_fun=2 accepted at the first edge.
